sysid_checker: RTL and testbench

- Boot-time integrity sequencer for the Qsys system-ID slave.
- On a start pulse it reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- A mismatch triggers a bounded number of retries, then pass/fail status is reported.
- Sits beside the sysid slave; gates software/decryption start-up on a matching hardware build.

---
 rtl/sysid_pkg.sv | 18 +
 rtl/sysid_checker.sv | 110 +++++++++++
 tb/tb_sysid_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1522822340;

endpackage

// File: rtl/sysid_checker.sv
// Boot-time sequencer: reads sysid ID/timestamp words, compares against build
// values with bounded retries, and reports sticky pass/fail status.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEF_EXPECTED_TS,
  parameter int          READ_LATENCY = 0,
  parameter int          MAX_ATTEMPTS = 3,
  localparam int         AW = $clog2(MAX_ATTEMPTS + 1),
  localparam int         CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          sysid_address,
  input  logic [31:0]   sysid_readdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail_id,
  output logic          fail_ts,
  output logic [31:0]   id_word,
  output logic [31:0]   ts_word,
  output logic [AW-1:0] attempts
);

  state_e        state, state_nx;
  logic [CW-1:0] wcnt;
  logic          lat_hit, match_id, match_ts, last_try;

  // Counter only ever reaches READ_LATENCY, so it cannot wrap.
  assign lat_hit  = (wcnt == CW'(READ_LATENCY));
  assign match_id = (id_word == EXPECTED_ID);
  assign match_ts = (ts_word == EXPECTED_TS);
  assign last_try = (attempts == AW'(MAX_ATTEMPTS));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)   state_nx = RD_ID;
      RD_ID:   if (lat_hit) state_nx = RD_TS;
      RD_TS:   if (lat_hit) state_nx = CHECK;
      CHECK: begin
        if (match_id && match_ts) state_nx = DONE;
        else if (!last_try)       state_nx = RD_ID;
        else                      state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sysid_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy          = (state != IDLE);
    done          = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt     <= '0;
      id_word  <= '0;
      ts_word  <= '0;
      pass     <= 1'b0;
      fail_id  <= 1'b0;
      fail_ts  <= 1'b0;
      attempts <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pass     <= 1'b0;
          fail_id  <= 1'b0;
          fail_ts  <= 1'b0;
          attempts <= AW'(1);
          wcnt     <= '0;
        end
        RD_ID: begin
          if (lat_hit) begin
            id_word <= sysid_readdata;
            wcnt    <= '0;
          end else wcnt <= wcnt + CW'(1);
        end
        RD_TS: begin
          if (lat_hit) begin
            ts_word <= sysid_readdata;
            wcnt    <= '0;
          end else wcnt <= wcnt + CW'(1);
        end
        CHECK: begin
          if (match_id && match_ts) pass <= 1'b1;
          else if (!last_try) begin
            attempts <= attempts + AW'(1);
            wcnt     <= '0;
          end else begin
            fail_id <= !match_id;
            fail_ts <= !match_ts;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (latency 0 and 2) driven by a
// behavioural slave whose per-attempt read values come from tables.
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1522822340;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst [2], st [2], addr [2], busy [2], done [2];
  logic        pass [2], fid [2], fts [2];
  logic [31:0] rdat [2], idw [2], tsw [2];
  logic [1:0]  att [2];

  logic [31:0] id_tab [2][3];
  logic [31:0] ts_tab [2][3];
  int          aidx [2];
  int          total = 0, bad = 0;

  assign rdat[0] = addr[0] ? ts_tab[0][aidx[0]] : id_tab[0][aidx[0]];
  assign rdat[1] = addr[1] ? ts_tab[1][aidx[1]] : id_tab[1][aidx[1]];

  sysid_checker #(.READ_LATENCY(0)) dut0 (
    .clock(clock), .reset(rst[0]), .start(st[0]), .sysid_address(addr[0]),
    .sysid_readdata(rdat[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_id(fid[0]), .fail_ts(fts[0]), .id_word(idw[0]), .ts_word(tsw[0]),
    .attempts(att[0]));

  sysid_checker #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(rst[1]), .start(st[1]), .sysid_address(addr[1]),
    .sysid_readdata(rdat[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_id(fid[1]), .fail_ts(fts[1]), .id_word(idw[1]), .ts_word(tsw[1]),
    .attempts(att[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, ".addr"}, 32'(addr[d]), 32'd0);
    chk({tag, ".busy"}, 32'(busy[d]), 32'd0);
    chk({tag, ".done"}, 32'(done[d]), 32'd0);
    chk({tag, ".pass"}, 32'(pass[d]), 32'd0);
    chk({tag, ".fail_id"}, 32'(fid[d]), 32'd0);
    chk({tag, ".fail_ts"}, 32'(fts[d]), 32'd0);
    chk({tag, ".id_word"}, idw[d], 32'd0);
    chk({tag, ".ts_word"}, tsw[d], 32'd0);
    chk({tag, ".attempts"}, 32'(att[d]), 32'd0);
  endtask

  // mode 0: good, 1: timestamp always bad, 2: ID bad on attempt 1 only, 3: random
  task automatic set_tab(input int d, input int mode);
    for (int a = 0; a < 3; a++) begin
      id_tab[d][a] = EXP_ID;
      ts_tab[d][a] = EXP_TS;
      case (mode)
        1: ts_tab[d][a] = 32'hDEADBEEF;
        2: if (a == 0) id_tab[d][a] = 32'h0000_0BAD;
        3: begin
          if ($urandom_range(0, 2) == 0) id_tab[d][a] = $urandom | 32'd1;
          if ($urandom_range(0, 2) == 0) ts_tab[d][a] = $urandom ^ EXP_TS ^ 32'h8000_0000;
        end
        default: ;
      endcase
    end
  endtask

  // Entered at a negedge in IDLE (cycle 0); returns at the negedge of the IDLE
  // cycle after DONE. hold keeps start high throughout; poke pulses start in cycle 2.
  task automatic run_seq(input int d, input int L, input bit hold, input bit poke, input string tag);
    int  n, per, dc, a, o;
    bit  ok;
    logic exp_addr;
    ok = 1'b0;
    n  = 3;
    for (int k = 0; k < 3; k++)
      if (!ok && id_tab[d][k] == EXP_ID && ts_tab[d][k] == EXP_TS) begin
        ok = 1'b1;
        n  = k + 1;
      end
    per = 2 * L + 3;
    dc  = 4 + 2 * L + (n - 1) * per;
    st[d]   = 1'b1;
    aidx[d] = 0;
    for (int c = 1; c <= dc; c++) begin
      @(negedge clock);
      a = (c - 1) / per;
      o = (c - 1) % per;
      if (a > 2) a = 2;
      aidx[d] = a;
      if (!hold) st[d] = (poke && c == 2);
      exp_addr = (o > L && o <= 2 * L + 1);
      chk({tag, ".addr"}, 32'(addr[d]), 32'(exp_addr));
      chk({tag, ".busy"}, 32'(busy[d]), 32'd1);
      chk({tag, ".done"}, 32'(done[d]), 32'(c == dc));
      if (c < dc) chk({tag, ".attempts_run"}, 32'(att[d]), 32'(a + 1));
      if (c == 1) chk({tag, ".pass_clr"}, 32'(pass[d]), 32'd0);
      if (c == dc) begin
        chk({tag, ".pass"}, 32'(pass[d]), 32'(ok));
        chk({tag, ".fail_id"}, 32'(fid[d]), 32'(!ok && id_tab[d][n-1] != EXP_ID));
        chk({tag, ".fail_ts"}, 32'(fts[d]), 32'(!ok && ts_tab[d][n-1] != EXP_TS));
        chk({tag, ".attempts"}, 32'(att[d]), 32'(n));
        chk({tag, ".id_word"}, idw[d], id_tab[d][n-1]);
        chk({tag, ".ts_word"}, tsw[d], ts_tab[d][n-1]);
      end
    end
    @(negedge clock);
    chk({tag, ".idle_busy"}, 32'(busy[d]), 32'd0);
    chk({tag, ".idle_done"}, 32'(done[d]), 32'd0);
    chk({tag, ".pass_sticky"}, 32'(pass[d]), 32'(ok));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; st[d] = 1'b0; aidx[d] = 0;
      set_tab(d, 0);
    end
    repeat (3) @(negedge clock);
    chk_zero(0, "reset0");
    chk_zero(1, "reset2");
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clock);

    run_seq(0, 0, 1'b0, 1'b0, "good_L0");
    run_seq(1, 2, 1'b0, 1'b0, "good_L2");
    set_tab(0, 1); run_seq(0, 0, 1'b0, 1'b0, "badts_L0");
    set_tab(1, 1); run_seq(1, 2, 1'b0, 1'b0, "badts_L2");
    set_tab(0, 2); run_seq(0, 0, 1'b0, 1'b0, "retry_L0");
    set_tab(1, 2); run_seq(1, 2, 1'b0, 1'b0, "retry_L2");

    // Reset in RD_TS (cycle 2 at latency 0)
    set_tab(0, 0);
    st[0] = 1'b1;
    @(negedge clock); st[0] = 1'b0;
    @(negedge clock);
    chk("rst_mid.addr_rdts", 32'(addr[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clock);
    chk_zero(0, "rst_mid");
    rst[0] = 1'b0;
    @(negedge clock);
    chk("rst_mid.idle", 32'(busy[0]), 32'd0);
    run_seq(0, 0, 1'b0, 1'b0, "after_rst");

    // Mid-sequence start ignored; held start restarts right after IDLE
    set_tab(0, 1); run_seq(0, 0, 1'b1, 1'b1, "hold_a");
    set_tab(0, 0); run_seq(0, 0, 1'b0, 1'b0, "hold_b");
    set_tab(1, 2); run_seq(1, 2, 1'b0, 1'b1, "poke_L2");

    for (int i = 0; i < 6; i++) begin
      set_tab(0, 3); run_seq(0, 0, 1'b0, 1'b0, "rand_L0");
      set_tab(1, 3); run_seq(1, 2, 1'b0, 1'b0, "rand_L2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
